inout_pair_sequencer: RTL and testbench

//  Sequences the INOUT_GEN pair-address ROM to move one 256-coefficient polynomial between a

---
 rtl/inout_pair_sequencer.sv | 160 ++++++++++++++++
 tb/tb_inout_pair_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inout_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module : inout_pair_sequencer
// Walks the pair-address ROM to load or unload one polynomial between the
// stream ports and the dual-port coefficient RAM, one coefficient pair per entry.
// Rev    : 1.0
// ============================================================================
module inout_pair_sequencer #(
    parameter int DW      = 12,
    parameter int AW      = 8,
    parameter int ROM_AW  = 9,
    parameter int N_PAIRS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                mode_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [ROM_AW-1:0]   rom_addr_o,
    input  logic [3*AW-1:0]     rom_data_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [2*DW-1:0]     in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [2*DW-1:0]     out_data_o,
    output logic                ram_en_o,
    output logic                ram_we_a_o,
    output logic                ram_we_b_o,
    output logic [AW-1:0]       ram_addr_a_o,
    output logic [AW-1:0]       ram_addr_b_o,
    output logic [DW-1:0]       ram_din_a_o,
    output logic [DW-1:0]       ram_din_b_o,
    input  logic [DW-1:0]       ram_q_a_i,
    input  logic [DW-1:0]       ram_q_b_i
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PREFETCH  = 3'd1,
        S_LOAD_WAIT = 3'd2,
        S_RD        = 3'd3,
        S_CAP       = 3'd4,
        S_OUT       = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam logic [ROM_AW-1:0] c_last_idx = ROM_AW'(N_PAIRS - 1);

    state_t              state_q;
    logic [ROM_AW-1:0]   idx_q;
    logic [ROM_AW-1:0]   idx_d;
    logic                mode_q;
    logic                busy_q;
    logic                done_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [2*DW-1:0]     out_data_q;

    logic                w_last;
    logic                w_load_wr;
    logic                w_unused_rom_lsb;

    assign w_last           = (idx_q == c_last_idx);
    assign idx_d            = idx_q + ROM_AW'(1);
    assign w_unused_rom_lsb = ^rom_data_i[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q  <= mode_i;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_PREFETCH;
                    end
                end
                S_PREFETCH: begin
                    if (mode_q) begin
                        state_q <= S_RD;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= S_LOAD_WAIT;
                    end
                end
                S_LOAD_WAIT: begin
                    if (in_valid_i) begin
                        in_ready_q <= 1'b0;
                        if (w_last) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_d;
                            state_q <= S_PREFETCH;
                        end
                    end
                end
                S_RD: begin
                    state_q <= S_CAP;
                end
                S_CAP: begin
                    out_data_q  <= {ram_q_a_i, ram_q_b_i};
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        if (w_last) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_d;
                            state_q <= S_PREFETCH;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // RAM strobes follow in_valid combinationally so a load pair completes in one LOAD_WAIT cycle.
    assign w_load_wr    = (state_q == S_LOAD_WAIT) && in_valid_i;
    assign ram_en_o     = w_load_wr || (state_q == S_RD);
    assign ram_we_a_o   = w_load_wr;
    assign ram_we_b_o   = w_load_wr && (ram_addr_a_o != ram_addr_b_o);
    assign ram_addr_a_o = rom_data_i[3*AW-1:2*AW];
    assign ram_addr_b_o = rom_data_i[2*AW-1:AW];
    assign ram_din_a_o  = in_data_i[2*DW-1:DW];
    assign ram_din_b_o  = in_data_i[DW-1:0];

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rom_addr_o  = idx_q;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_inout_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_inout_pair_sequencer
// Scoreboard bench for inout_pair_sequencer with behavioural ROM and RAM models.
// Rev    : 1.0
// ============================================================================
module tb_inout_pair_sequencer;

    localparam int DW      = 12;
    localparam int AW      = 8;
    localparam int ROM_AW  = 9;
    localparam int N_PAIRS = 128;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start_i = 1'b0;
    logic               mode_i = 1'b0;
    logic               in_valid_i = 1'b0;
    logic               out_ready_i = 1'b0;
    logic [2*DW-1:0]    in_data_i = '0;
    logic [3*AW-1:0]    rom_data_i;
    logic [DW-1:0]      ram_q_a_i;
    logic [DW-1:0]      ram_q_b_i;
    logic               busy_o, done_o, in_ready_o, out_valid_o;
    logic               ram_en_o, ram_we_a_o, ram_we_b_o;
    logic [ROM_AW-1:0]  rom_addr_o;
    logic [2*DW-1:0]    out_data_o;
    logic [AW-1:0]      ram_addr_a_o, ram_addr_b_o;
    logic [DW-1:0]      ram_din_a_o, ram_din_b_o;

    inout_pair_sequencer #(.DW(DW), .AW(AW), .ROM_AW(ROM_AW), .N_PAIRS(N_PAIRS)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
        .busy_o(busy_o), .done_o(done_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .ram_en_o(ram_en_o), .ram_we_a_o(ram_we_a_o), .ram_we_b_o(ram_we_b_o),
        .ram_addr_a_o(ram_addr_a_o), .ram_addr_b_o(ram_addr_b_o),
        .ram_din_a_o(ram_din_a_o), .ram_din_b_o(ram_din_b_o),
        .ram_q_a_i(ram_q_a_i), .ram_q_b_i(ram_q_b_i)
    );

    always #5 clk = ~clk;

    logic [3*AW-1:0] rom_mem [0:(1<<ROM_AW)-1];
    logic [DW-1:0]   ram_mem [0:(1<<AW)-1];
    logic            preload_req = 1'b0;
    int              cyc = 0;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        rom_data_i <= rom_mem[rom_addr_o];
        if (preload_req) begin
            for (int k = 0; k < (1<<AW); k++) ram_mem[k] <= DW'(k);
        end else if (ram_en_o) begin
            if (ram_we_a_o) ram_mem[ram_addr_a_o] <= ram_din_a_o;
            if (ram_we_b_o) ram_mem[ram_addr_b_o] <= ram_din_b_o;
            ram_q_a_i <= ram_mem[ram_addr_a_o];
            ram_q_b_i <= ram_mem[ram_addr_b_o];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [DW-1:0] da;
        logic [DW-1:0] db;
        logic          web;
    } wr_t;

    wr_t             wr_q [$];
    logic [2*DW-1:0] rd_q [$];

    function automatic logic [2*DW-1:0] pat(input int i, input int sel);
        if (sel == 0) return (2*DW)'(i);
        return {DW'((i*7 + sel) % 3329), DW'((i*13 + 3*sel + 1) % 3329)};
    endfunction

    function automatic logic [DW-1:0] pat_hi(input int i, input int sel);
        logic [2*DW-1:0] p;
        p = pat(i, sel);
        return p[2*DW-1:DW];
    endfunction

    function automatic logic [DW-1:0] pat_lo(input int i, input int sel);
        logic [2*DW-1:0] p;
        p = pat(i, sel);
        return p[DW-1:0];
    endfunction

    task automatic push_wr(input int i, input int sel);
        wr_t             e;
        logic [3*AW-1:0] r;
        r     = rom_mem[i];
        e.a   = r[3*AW-1:2*AW];
        e.b   = r[2*AW-1:AW];
        e.da  = pat_hi(i, sel);
        e.db  = pat_lo(i, sel);
        e.web = (e.a != e.b);
        wr_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, pops the scoreboards and checks stall stability.
    int              done_cnt = 0;
    int              done_cyc = 0;
    logic            prev_ir_stall = 1'b0;
    logic            prev_ov_stall = 1'b0;
    logic [2*DW-1:0] prev_od = '0;
    wr_t             mon_e;
    logic [2*DW-1:0] mon_r;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_ir_stall) check_eq("in_ready_hold", in_ready_o, 1);
            if (prev_ov_stall) begin
                check_eq("out_valid_hold", out_valid_o, 1);
                check_eq("out_data_hold", out_data_o, prev_od);
            end
            if (ram_we_b_o && !ram_we_a_o) check_eq("we_b_alone", 1, 0);
            if (ram_en_o && ram_we_a_o) begin
                if (wr_q.size() == 0) begin
                    check_eq("wr_unexpected", 1, 0);
                end else begin
                    mon_e = wr_q.pop_front();
                    check_eq("wr_addr_a", ram_addr_a_o, mon_e.a);
                    check_eq("wr_din_a", ram_din_a_o, mon_e.da);
                    check_eq("wr_we_b", ram_we_b_o, mon_e.web);
                    if (mon_e.web) begin
                        check_eq("wr_addr_b", ram_addr_b_o, mon_e.b);
                        check_eq("wr_din_b", ram_din_b_o, mon_e.db);
                    end
                end
            end
            if (out_valid_o && out_ready_i) begin
                if (rd_q.size() == 0) begin
                    check_eq("rd_unexpected", 1, 0);
                end else begin
                    mon_r = rd_q.pop_front();
                    check_eq("out_data", out_data_o, mon_r);
                end
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                check_eq("busy_at_done", busy_o, 1);
            end
        end
        prev_ir_stall = rst_n && in_ready_o && !in_valid_i;
        prev_ov_stall = rst_n && out_valid_o && !out_ready_i;
        prev_od       = out_data_o;
    end

    int s_cyc = 0;

    task automatic pulse_start(input logic m);
        @(posedge clk); #1;
        start_i = 1'b1;
        mode_i  = m;
        @(posedge clk); #1;
        s_cyc   = cyc;
        start_i = 1'b0;
        mode_i  = ~m;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, busy_o, 0);
        check_eq({tag, "_done"}, done_o, 0);
        check_eq({tag, "_in_ready"}, in_ready_o, 0);
        check_eq({tag, "_out_valid"}, out_valid_o, 0);
        check_eq({tag, "_ram_en"}, {ram_en_o, ram_we_a_o, ram_we_b_o}, 0);
        check_eq({tag, "_rom_addr"}, rom_addr_o, 0);
        check_eq({tag, "_out_data"}, out_data_o, 0);
    endtask

    task automatic finish_run(input int d0, input int exp_lat);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_seen", done_cnt - d0, 1);
        if (exp_lat > 0) check_eq("done_latency", done_cyc - s_cyc, exp_lat);
        repeat (4) @(negedge clk);
        check_eq("done_once", done_cnt - d0, 1);
        check_eq("idle_busy", busy_o, 0);
        check_eq("idle_rom_addr", rom_addr_o, 0);
    endtask

    task automatic run_load(input int sel, input int pct, input int abort_at,
                            input int dup_at, input int exp_lat);
        int   k, budget, d0;
        logic hs;
        d0 = done_cnt;
        k  = 0;
        budget = 0;
        push_wr(0, sel);
        in_data_i  = pat(0, sel);
        in_valid_i = ($urandom_range(99) < pct);
        pulse_start(1'b0);
        while (k < N_PAIRS && budget < 4000) begin
            @(negedge clk);
            hs = in_valid_i && in_ready_o;
            @(posedge clk); #1;
            budget++;
            if (hs) begin
                k++;
                if (k < N_PAIRS) begin
                    push_wr(k, sel);
                    in_data_i = pat(k, sel);
                end
            end
            in_valid_i = ($urandom_range(99) < pct);
            start_i    = (hs && k == dup_at);
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                in_valid_i = 1'b0;
                start_i    = 1'b0;
                wr_q.delete();
                repeat (3) @(negedge clk);
                check_eq("abort_no_done", done_cnt - d0, 0);
                return;
            end
        end
        in_valid_i = 1'b0;
        start_i    = 1'b0;
        check_eq("load_pairs", k, N_PAIRS);
        check_eq("load_sb_empty", wr_q.size(), 0);
        finish_run(d0, exp_lat);
    endtask

    task automatic run_unload(input int sel, input int pct, input int exp_lat);
        int d0, budget;
        d0 = done_cnt;
        budget = 0;
        for (int i = 0; i < N_PAIRS; i++) begin
            if (sel < 0) rd_q.push_back({DW'(2*i), DW'(2*i + 1)});
            else         rd_q.push_back(pat(i, sel));
        end
        pulse_start(1'b1);
        out_ready_i = ($urandom_range(99) < pct);
        while ((rd_q.size() != 0 || done_cnt == d0) && budget < 6000) begin
            @(posedge clk); #1;
            budget++;
            out_ready_i = ($urandom_range(99) < pct);
        end
        out_ready_i = 1'b0;
        check_eq("unload_sb_empty", rd_q.size(), 0);
        rd_q.delete();
        finish_run(d0, exp_lat);
    endtask

    initial begin
        for (int i = 0; i < (1<<ROM_AW); i++) rom_mem[i] = {AW'(2*i), AW'(2*i + 1), AW'(0)};
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Full-rate load with in_data = pair index.
        run_load(0, 100, -1, -1, 256);
        check_eq("t1_ram0", ram_mem[0], pat_hi(0, 0));
        check_eq("t1_ram1", ram_mem[1], pat_lo(0, 0));
        check_eq("t1_ram255", ram_mem[255], pat_lo(127, 0));

        // Full-rate unload of identity RAM.
        @(posedge clk); #1 preload_req = 1'b1;
        @(posedge clk); #1 preload_req = 1'b0;
        run_unload(-1, 100, 512);

        // Throttled load then throttled unload of the same data.
        run_load(5, 50, -1, -1, 0);
        run_unload(5, 50, 0);

        // Second start while busy must be ignored.
        run_load(9, 100, -1, 40, 256);

        // Aliased addresses: port A wins, port B not written.
        rom_mem[3] = {AW'(5), AW'(5), AW'(0)};
        run_load(11, 100, -1, -1, 256);
        check_eq("t4_ram5", ram_mem[5], pat_hi(3, 11));
        rom_mem[3] = {AW'(6), AW'(7), AW'(0)};

        // Reset mid-run keeps earlier writes; a new start begins at pair 0.
        run_load(13, 100, 60, -1, 0);
        for (int i = 0; i < 60; i++) begin
            check_eq("t6_keep_a", ram_mem[2*i], pat_hi(i, 13));
            check_eq("t6_keep_b", ram_mem[2*i + 1], pat_lo(i, 13));
        end
        check_eq("t6_untouched", ram_mem[120], pat_hi(60, 11));
        @(posedge clk); #1 rst_n = 1'b1;
        run_load(17, 100, -1, -1, 256);
        check_eq("t6_restart_ram0", ram_mem[0], pat_hi(0, 17));
        check_eq("t6_restart_ram255", ram_mem[255], pat_lo(127, 17));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
